// File: rtl/forwarding_if.sv
// Issue-stage operand bypass bundle: read ports, pipeline stage writebacks, long-latency
// completion, commit write and the forwarded operands / stall returned to issue.
interface forwarding_if #(
  parameter int XLEN   = 32,
  parameter int NREAD  = 2,
  parameter int NSTAGE = 2,
  parameter int NREG   = 32,
  parameter int CNTW   = 16
);
  localparam int AW = $clog2(NREG);

  logic [NREAD-1:0]       rden;
  logic [NREAD*AW-1:0]    raddr;
  logic [NREAD*XLEN-1:0]  rdata;
  logic [NSTAGE-1:0]      stg_wren;
  logic [NSTAGE*AW-1:0]   stg_waddr;
  logic [NSTAGE*XLEN-1:0] stg_wdata;
  logic [NSTAGE-1:0]      stg_wvalid;
  logic                   lat_issue;
  logic [AW-1:0]          lat_waddr;
  logic                   lat_done;
  logic [AW-1:0]          lat_daddr;
  logic [XLEN-1:0]        lat_ddata;
  logic                   cmt_wren;
  logic [AW-1:0]          cmt_waddr;
  logic [XLEN-1:0]        cmt_wdata;
  logic                   flush;
  logic [NREAD*XLEN-1:0]  data;
  logic                   stall;
  logic [CNTW-1:0]        stall_cnt;
  // Observation of internal state: scoreboard bits and commit-buffer occupancy.
  logic [NREG-1:0]        dbg_pending;
  logic                   dbg_cbuf_valid;

  // No valid/ready pairing here: every input is sampled each cycle; stall is the only back-pressure.
  modport slave (
    input  rden, raddr, rdata, stg_wren, stg_waddr, stg_wdata, stg_wvalid,
    input  lat_issue, lat_waddr, lat_done, lat_daddr, lat_ddata,
    input  cmt_wren, cmt_waddr, cmt_wdata, flush,
    output data, stall, stall_cnt, dbg_pending, dbg_cbuf_valid
  );

  modport master (
    output rden, raddr, rdata, stg_wren, stg_waddr, stg_wdata, stg_wvalid,
    output lat_issue, lat_waddr, lat_done, lat_daddr, lat_ddata,
    output cmt_wren, cmt_waddr, cmt_wdata, flush,
    input  data, stall, stall_cnt, dbg_pending, dbg_cbuf_valid
  );
endinterface

// File: rtl/forwarding_unit.sv
// Operand bypass and hazard detection for the issue stage: stage/long-latency/commit-buffer
// forwarding per read port, a per-register pending-write scoreboard and a stall counter.
module forwarding_unit #(
  parameter int XLEN   = 32,
  parameter int NREAD  = 2,
  parameter int NSTAGE = 2,
  parameter int NREG   = 32,
  parameter int CNTW   = 16
) (
  input logic          clock,
  input logic          reset,
  forwarding_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  logic [NREG-1:0]       pending;
  logic [NREG-1:0]       pending_nxt;
  logic                  cbuf_valid;
  logic [AW-1:0]         cbuf_addr;
  logic [XLEN-1:0]       cbuf_data;
  logic [CNTW-1:0]       stall_cnt;

  logic [NREAD*XLEN-1:0] data_flat;
  logic [NREAD-1:0]      hazard;
  logic [AW-1:0]         addr;
  logic [XLEN-1:0]       sel;
  logic                  stg_hit;
  logic                  stg_ok;
  logic                  lat_hit;

  // Per port: sources are layered lowest priority first so the youngest matching stage wins last.
  always_comb begin
    data_flat = '0;
    hazard    = '0;
    addr      = '0;
    sel       = '0;
    stg_hit   = 1'b0;
    stg_ok    = 1'b1;
    lat_hit   = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      addr    = bus.raddr[p*AW +: AW];
      sel     = bus.rdata[p*XLEN +: XLEN];
      stg_hit = 1'b0;
      stg_ok  = 1'b1;
      lat_hit = bus.lat_done && (bus.lat_daddr == addr);
      if (cbuf_valid && (cbuf_addr == addr)) sel = cbuf_data;
      if (lat_hit) sel = bus.lat_ddata;
      for (int s = NSTAGE - 1; s >= 0; s--) begin
        if (bus.stg_wren[s] && (bus.stg_waddr[s*AW +: AW] == addr)) begin
          stg_hit = 1'b1;
          stg_ok  = bus.stg_wvalid[s];
          sel     = bus.stg_wdata[s*XLEN +: XLEN];
        end
      end
      if (bus.rden[p] && (addr != '0)) begin
        data_flat[p*XLEN +: XLEN] = sel;
        hazard[p] = (stg_hit && !stg_ok) || (pending[addr] && !stg_hit && !lat_hit);
      end
    end
  end

  assign bus.data           = data_flat;
  assign bus.stall          = |hazard;
  assign bus.stall_cnt      = stall_cnt;
  assign bus.dbg_pending    = pending;
  assign bus.dbg_cbuf_valid = cbuf_valid;

  // Issue after completion on the same register leaves it pending; flush drops same-cycle issue.
  always_comb begin
    pending_nxt = pending;
    if (bus.flush) begin
      pending_nxt = '0;
    end else begin
      if (bus.lat_done && (bus.lat_daddr != '0)) pending_nxt[bus.lat_daddr] = 1'b0;
      if (bus.lat_issue && (bus.lat_waddr != '0)) pending_nxt[bus.lat_waddr] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // One-cycle copy of the register-file write, covering a read that sampled the old value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cbuf_valid <= 1'b0;
      cbuf_addr  <= '0;
      cbuf_data  <= '0;
    end else if (bus.cmt_wren && (bus.cmt_waddr != '0)) begin
      cbuf_valid <= 1'b1;
      cbuf_addr  <= bus.cmt_waddr;
      cbuf_data  <= bus.cmt_wdata;
    end else begin
      cbuf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (bus.stall && (stall_cnt != {CNTW{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_forwarding_unit.sv
// Bench for forwarding_unit: directed hazard/priority scenarios plus a random stall run
// checked through an expected-value queue.
module tb_forwarding_unit;
  localparam int XLEN   = 32;
  localparam int NREAD  = 2;
  localparam int NSTAGE = 2;
  localparam int NREG   = 32;
  localparam int CNTW   = 4;
  localparam int AW     = $clog2(NREG);
  localparam int W      = 1 + NREG + CNTW + 1 + 2 * XLEN;

  logic clock;
  logic reset;

  forwarding_if #(.XLEN(XLEN), .NREAD(NREAD), .NSTAGE(NSTAGE), .NREG(NREG), .CNTW(CNTW)) bus ();

  forwarding_unit #(.XLEN(XLEN), .NREAD(NREAD), .NSTAGE(NSTAGE), .NREG(NREG), .CNTW(CNTW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard state
  logic [W-1:0]    exp_q[$];
  logic [CNTW-1:0] exp_cnt;
  int              n_cmp;
  int              n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic idle();
    bus.rden       = '0;
    bus.raddr      = '0;
    bus.rdata      = '0;
    bus.stg_wren   = '0;
    bus.stg_waddr  = '0;
    bus.stg_wdata  = '0;
    bus.stg_wvalid = '0;
    bus.lat_issue  = 1'b0;
    bus.lat_waddr  = '0;
    bus.lat_done   = 1'b0;
    bus.lat_daddr  = '0;
    bus.lat_ddata  = '0;
    bus.cmt_wren   = 1'b0;
    bus.cmt_waddr  = '0;
    bus.cmt_wdata  = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic set_read(input int p, input logic en, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus.rden[p]                 = en;
    bus.raddr[p*AW +: AW]       = a;
    bus.rdata[p*XLEN +: XLEN]   = d;
  endtask

  task automatic set_stage(input int s, input logic en, input logic [AW-1:0] a,
                           input logic [XLEN-1:0] d, input logic v);
    bus.stg_wren[s]               = en;
    bus.stg_waddr[s*AW +: AW]     = a;
    bus.stg_wdata[s*XLEN +: XLEN] = d;
    bus.stg_wvalid[s]             = v;
  endtask

  task automatic push_exp(input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1, input logic st,
                          input logic [NREG-1:0] pend, input logic cbv);
    exp_q.push_back({cbv, pend, exp_cnt, st, d1, d0});
  endtask

  // Sample at the falling edge, compare against the oldest expectation, then move past the next rising edge.
  task automatic sample(input string tag);
    logic [W-1:0] e;
    @(negedge clock);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no expectation queued", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".data0"}, bus.data[XLEN-1:0], e[XLEN-1:0]);
      check({tag, ".data1"}, bus.data[2*XLEN-1:XLEN], e[2*XLEN-1:XLEN]);
      check({tag, ".stall"}, 32'(bus.stall), 32'(e[2*XLEN]));
      check({tag, ".cnt"}, 32'(bus.stall_cnt), 32'(e[2*XLEN+1 +: CNTW]));
      check({tag, ".pend"}, bus.dbg_pending, e[2*XLEN+1+CNTW +: NREG]);
      check({tag, ".cbuf"}, 32'(bus.dbg_cbuf_valid), 32'(e[W-1]));
      if (e[2*XLEN] && exp_cnt != {CNTW{1'b1}}) exp_cnt++;
    end
    @(posedge clock);
    #1;
  endtask

  localparam logic [NREG-1:0] B4  = 32'h1 << 4;
  localparam logic [NREG-1:0] B6  = 32'h1 << 6;
  localparam logic [NREG-1:0] B9  = 32'h1 << 9;
  localparam logic [NREG-1:0] B10 = 32'h1 << 10;

  initial begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic [XLEN-1:0] wd;
    n_cmp   = 0;
    n_err   = 0;
    exp_cnt = '0;
    reset   = 1'b0;
    idle();
    repeat (2) @(posedge clock);
    #1;
    push_exp(0, 0, 0, 0, 0);
    sample("reset");
    reset = 1'b1;

    // stage priority, then lat_done and commit buffer below the stages
    idle();
    set_read(0, 1, 5, 32'h33);
    set_stage(0, 1, 5, 32'h11, 1);
    set_stage(1, 1, 5, 32'h22, 1);
    push_exp(32'h11, 0, 0, 0, 0);
    sample("prio_stg0");
    set_stage(0, 0, 0, 0, 0);
    set_read(1, 1, 5, 32'h44);
    push_exp(32'h22, 32'h22, 0, 0, 0);
    sample("prio_stg1");
    set_stage(1, 0, 0, 0, 0);
    push_exp(32'h33, 32'h44, 0, 0, 0);
    sample("prio_rdata");

    idle();
    set_read(0, 1, 12, 32'hAA);
    bus.cmt_wren = 1'b1; bus.cmt_waddr = 12; bus.cmt_wdata = 32'hC1;
    push_exp(32'hAA, 0, 0, 0, 0);
    sample("layer_a");
    set_stage(1, 1, 12, 32'hE1, 1);
    bus.lat_done = 1'b1; bus.lat_daddr = 12; bus.lat_ddata = 32'hD1;
    push_exp(32'hE1, 0, 0, 0, 1);
    sample("layer_stg");
    set_stage(1, 0, 0, 0, 0);
    push_exp(32'hD1, 0, 0, 0, 1);
    sample("layer_lat");
    bus.lat_done = 1'b0;
    bus.cmt_wren = 1'b0;
    push_exp(32'hC1, 0, 0, 0, 1);
    sample("layer_cbuf");
    push_exp(32'hAA, 0, 0, 0, 0);
    sample("layer_rf");

    // register 0 never forwards, stalls, becomes pending or fills the commit buffer
    idle();
    set_read(0, 1, 0, 32'h77);
    set_stage(0, 1, 0, 32'hFF, 0);
    bus.lat_issue = 1'b1; bus.lat_waddr = 0;
    bus.cmt_wren  = 1'b1; bus.cmt_waddr = 0; bus.cmt_wdata = 32'h99;
    push_exp(0, 0, 0, 0, 0);
    sample("x0");
    idle();
    push_exp(0, 0, 0, 0, 0);
    sample("x0_after");

    // load-use
    set_read(0, 1, 7, 32'h01);
    set_stage(0, 1, 7, 32'h70, 0);
    push_exp(32'h70, 0, 1, 0, 0);
    sample("load_use");
    set_stage(0, 1, 7, 32'h70, 1);
    push_exp(32'h70, 0, 0, 0, 0);
    sample("load_done");

    // scoreboard: pending long-latency write
    idle();
    bus.lat_issue = 1'b1; bus.lat_waddr = 9;
    push_exp(0, 0, 0, 0, 0);
    sample("lat_issue");
    bus.lat_issue = 1'b0;
    set_read(0, 1, 9, 32'h99);
    for (int i = 0; i < 3; i++) begin
      push_exp(32'h99, 0, 1, B9, 0);
      sample("lat_wait");
    end
    bus.lat_done = 1'b1; bus.lat_daddr = 9; bus.lat_ddata = 32'hABCD;
    push_exp(32'hABCD, 0, 0, B9, 0);
    sample("lat_done");
    bus.lat_done = 1'b0;
    push_exp(32'h99, 0, 0, 0, 0);
    sample("lat_clear");

    // commit buffer covers a stale register-file read
    idle();
    set_read(0, 1, 3, 32'h0);
    bus.cmt_wren = 1'b1; bus.cmt_waddr = 3; bus.cmt_wdata = 32'h55;
    push_exp(0, 0, 0, 0, 0);
    sample("cbuf_n");
    bus.cmt_wren = 1'b0;
    push_exp(32'h55, 0, 0, 0, 1);
    sample("cbuf_n1");
    set_read(0, 1, 3, 32'h56);
    push_exp(32'h56, 0, 0, 0, 0);
    sample("cbuf_n2");

    // random load-use run long enough to saturate the counter
    idle();
    for (int i = 0; i < 20; i++) begin
      ra = AW'($urandom_range(1, NREG - 1));
      rd = $urandom;
      wd = $urandom;
      set_read(0, 1, ra, rd);
      set_stage(0, 1, ra, wd, 0);
      push_exp(wd, 0, 1, 0, 0);
      sample("sat");
    end
    idle();
    push_exp(0, 0, 0, 0, 0);
    sample("sat_hold");

    // flush cancels pending writes and a same-cycle issue
    bus.lat_issue = 1'b1; bus.lat_waddr = 4;
    push_exp(0, 0, 0, 0, 0);
    sample("fl_issue4");
    bus.lat_waddr = 6;
    push_exp(0, 0, 0, B4, 0);
    sample("fl_issue6");
    bus.flush = 1'b1; bus.lat_waddr = 8;
    push_exp(0, 0, 0, B4 | B6, 0);
    sample("flush");
    idle();
    set_read(0, 1, 4, 32'h44);
    set_read(1, 1, 8, 32'h88);
    push_exp(32'h44, 32'h88, 0, 0, 0);
    sample("fl_read");

    // asynchronous reset in the middle of a stall
    idle();
    bus.lat_issue = 1'b1; bus.lat_waddr = 10;
    bus.cmt_wren  = 1'b1; bus.cmt_waddr = 11; bus.cmt_wdata = 32'hBB;
    push_exp(0, 0, 0, 0, 0);
    sample("rst_setup");
    bus.lat_issue = 1'b0;
    set_read(0, 1, 10, 32'hA0);
    push_exp(32'hA0, 0, 1, B10, 1);
    sample("rst_stall0");
    push_exp(32'hA0, 0, 1, B10, 1);
    sample("rst_stall1");
    reset   = 1'b0;
    exp_cnt = '0;
    push_exp(32'hA0, 0, 0, 0, 0);
    sample("rst_mid");
    reset = 1'b1;
    idle();
    push_exp(0, 0, 0, 0, 0);
    sample("rst_after");

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL queue_drain: %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
